// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg: shared types for the RV32I pipeline registers.
//   id_ex_t    - registered contents of the ID/EX stage
//   fwd_sel_e  - operand source choice made by fwd_unit
//   id_ex_clear() - the reset/flush value of id_ex_t (op = ALU_ADD)
// The ALU opcode type and encodings normally come from the shared ALU
// define header; the guarded block below only supplies them when that
// header has not already been seen in this compilation.

`ifndef ALU_si
`define ALU_si logic [3:0]
`define ALU_ADD 4'd0
`define ALU_SUB 4'd1
`define ALU_AND 4'd2
`define ALU_OR  4'd3
`define ALU_XOR 4'd4
`endif

package rv_pipe_pkg;

  // Widths of the registered fields; the stage parameters must match these.
  localparam int PIPE_XLEN    = 32;
  localparam int PIPE_RADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_EX = 2'd1,
    FWD_WB = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic                    valid;
    logic [PIPE_XLEN-1:0]    src1;
    logic [PIPE_XLEN-1:0]    src2;
    `ALU_si                  op;
    logic [PIPE_RADDR_W-1:0] rd_addr;
    logic                    is_load;
  } id_ex_t;

  function automatic id_ex_t id_ex_clear();
    id_ex_t c;
    c         = '0;
    c.op      = `ALU_ADD;
    return c;
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: combinational operand-source selection for both sources.
//   rs1_addr/rs2_addr, rs1_used/rs2_used : decoded sources
//   ex_we/ex_rd, wb_we/wb_rd             : EX/MEM and write-back buses
//   rs1_sel/rs2_sel                      : FWD_EX > FWD_WB > FWD_RF; x0 is always FWD_RF
//   rs1_hit/rs2_hit                      : source is read and matches a live bus

`ifndef ALU_si
`define ALU_si logic [3:0]
`define ALU_ADD 4'd0
`define ALU_SUB 4'd1
`define ALU_AND 4'd2
`define ALU_OR  4'd3
`define ALU_XOR 4'd4
`endif

module fwd_unit
  import rv_pipe_pkg::*;
#(
  parameter int RADDR_W = 5
) (
  input  logic [RADDR_W-1:0] rs1_addr,
  input  logic [RADDR_W-1:0] rs2_addr,
  input  logic               rs1_used,
  input  logic               rs2_used,
  input  logic               ex_we,
  input  logic [RADDR_W-1:0] ex_rd,
  input  logic               wb_we,
  input  logic [RADDR_W-1:0] wb_rd,
  output fwd_sel_e           rs1_sel,
  output fwd_sel_e           rs2_sel,
  output logic               rs1_hit,
  output logic               rs2_hit
);

  function automatic fwd_sel_e pick(input logic [RADDR_W-1:0] a,
                                    input logic               e_we,
                                    input logic [RADDR_W-1:0] e_rd,
                                    input logic               w_we,
                                    input logic [RADDR_W-1:0] w_rd);
    fwd_sel_e s;
    s = FWD_RF;
    if (a != '0) begin
      if (e_we && (e_rd == a))      s = FWD_EX;
      else if (w_we && (w_rd == a)) s = FWD_WB;
    end
    return s;
  endfunction

  assign rs1_sel = pick(rs1_addr, ex_we, ex_rd, wb_we, wb_rd);
  assign rs2_sel = pick(rs2_addr, ex_we, ex_rd, wb_we, wb_rd);

  assign rs1_hit = rs1_used && (rs1_sel != FWD_RF);
  assign rs2_hit = rs2_used && (rs2_sel != FWD_RF);

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the ALU.
//   Decode side : in_valid/in_ready, in_rs*_addr/used/data, in_imm, in_use_imm,
//                 in_rd_addr, in_is_load, in_op
//   Bypass      : ex_fwd_we/rd/data, wb_fwd_we/rd/data
//   Control     : stall_in (hold), flush (kill held instruction)
//   ALU side    : src1, src2, op, alu_enable (= out_valid)
//   To EX/MEM   : out_valid, out_rd_addr, out_is_load
// Build option ID_EX_FORWARD_EN: when defined, operands are bypassed from the
// EX and WB buses and only a load-use dependence stalls; when undefined there
// is no bypass and any dependence on the held, EX or WB result stalls.
// All outputs except in_ready come straight from the stage register.

`ifndef ALU_si
`define ALU_si logic [3:0]
`define ALU_ADD 4'd0
`define ALU_SUB 4'd1
`define ALU_AND 4'd2
`define ALU_OR  4'd3
`define ALU_XOR 4'd4
`endif

module id_ex_stage
  import rv_pipe_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [RADDR_W-1:0] in_rs1_addr,
  input  logic [RADDR_W-1:0] in_rs2_addr,
  input  logic               in_rs1_used,
  input  logic               in_rs2_used,
  input  logic [XLEN-1:0]    in_rs1_data,
  input  logic [XLEN-1:0]    in_rs2_data,
  input  logic [XLEN-1:0]    in_imm,
  input  logic               in_use_imm,
  input  logic [RADDR_W-1:0] in_rd_addr,
  input  logic               in_is_load,
  input  `ALU_si             in_op,
  input  logic               ex_fwd_we,
  input  logic [RADDR_W-1:0] ex_fwd_rd,
  input  logic [XLEN-1:0]    ex_fwd_data,
  input  logic               wb_fwd_we,
  input  logic [RADDR_W-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0]    wb_fwd_data,
  input  logic               stall_in,
  input  logic               flush,
  output logic [XLEN-1:0]    src1,
  output logic [XLEN-1:0]    src2,
  output `ALU_si             op,
  output logic               alu_enable,
  output logic               out_valid,
  output logic [RADDR_W-1:0] out_rd_addr,
  output logic               out_is_load
);

  id_ex_t          q;
  fwd_sel_e        rs1_sel, rs2_sel;
  logic            rs1_hit, rs2_hit;
  logic            dep1, dep2, pend, hazard;
  logic [XLEN-1:0] opnd1, opnd2;

  fwd_unit #(.RADDR_W(RADDR_W)) u_fwd (
    .rs1_addr (in_rs1_addr),
    .rs2_addr (in_rs2_addr),
    .rs1_used (in_rs1_used),
    .rs2_used (in_rs2_used),
    .ex_we    (ex_fwd_we),
    .ex_rd    (ex_fwd_rd),
    .wb_we    (wb_fwd_we),
    .wb_rd    (wb_fwd_rd),
    .rs1_sel  (rs1_sel),
    .rs2_sel  (rs2_sel),
    .rs1_hit  (rs1_hit),
    .rs2_hit  (rs2_hit)
  );

  // Dependence of the incoming instruction on the one held in this stage.
  // A nonzero source matching rd implies rd != 0.
  assign dep1 = in_rs1_used && (in_rs1_addr != '0) && (in_rs1_addr == q.rd_addr);
  assign dep2 = in_rs2_used && (in_rs2_addr != '0) && (in_rs2_addr == q.rd_addr);
  assign pend = q.valid && (dep1 || dep2);

`ifdef ID_EX_FORWARD_EN
  // Only a held load cannot be bypassed: its data reaches ex_fwd next cycle.
  assign hazard = pend && q.is_load;

  always_comb begin
    opnd1 = in_rs1_data;
    case (rs1_sel)
      FWD_EX:  opnd1 = ex_fwd_data;
      FWD_WB:  opnd1 = wb_fwd_data;
      default: opnd1 = in_rs1_data;
    endcase
  end

  always_comb begin
    opnd2 = in_rs2_data;
    case (rs2_sel)
      FWD_EX:  opnd2 = ex_fwd_data;
      FWD_WB:  opnd2 = wb_fwd_data;
      default: opnd2 = in_rs2_data;
    endcase
    if (in_use_imm) opnd2 = in_imm;
  end

  logic unused_fwd;
  assign unused_fwd = rs1_hit ^ rs2_hit;
`else
  // No bypass: wait until the producer has left every stage we could see.
  assign hazard = pend || rs1_hit || rs2_hit;
  assign opnd1  = in_rs1_data;
  assign opnd2  = in_use_imm ? in_imm : in_rs2_data;

  logic unused_fwd;
  assign unused_fwd = ^{ex_fwd_data, wb_fwd_data, rs1_sel, rs2_sel};
`endif

  // Handshake: an instruction transfers on a rising edge where in_valid and
  // in_ready are both 1. in_ready never looks at in_valid and is not lowered
  // by flush (decode is flushed by the same signal).
  assign in_ready = !stall_in && !hazard;

  // Priority: rst > flush > stall (hold) > hazard/empty bubble > accept.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      q <= id_ex_clear();
    end else if (!stall_in) begin
      if (in_valid && !hazard) begin
        q.valid   <= 1'b1;
        q.src1    <= opnd1;
        q.src2    <= opnd2;
        q.op      <= in_op;
        q.rd_addr <= in_rd_addr;
        q.is_load <= in_is_load;
      end else begin
        q.valid   <= 1'b0;
      end
    end
  end

  assign src1        = q.src1;
  assign src2        = q.src2;
  assign op          = q.op;
  assign out_valid   = q.valid;
  assign alu_enable  = q.valid;
  assign out_rd_addr = q.rd_addr;
  assign out_is_load = q.is_load;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven bench for id_ex_stage with a scoreboard queue.
// Works in both builds; the forwarding-specific sequences follow ID_EX_FORWARD_EN.

`ifndef ALU_si
`define ALU_si logic [3:0]
`define ALU_ADD 4'd0
`define ALU_SUB 4'd1
`define ALU_AND 4'd2
`define ALU_OR  4'd3
`define ALU_XOR 4'd4
`endif

module tb_id_ex_stage;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;
  localparam int EW      = 1 + 32 + 32 + 4 + 5 + 1 + 1;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready;
  logic [RADDR_W-1:0] in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic in_rs1_used, in_rs2_used, in_use_imm, in_is_load;
  logic [XLEN-1:0] in_rs1_data, in_rs2_data, in_imm;
  logic [3:0] in_op, op;
  logic ex_fwd_we, wb_fwd_we;
  logic [RADDR_W-1:0] ex_fwd_rd, wb_fwd_rd, out_rd_addr;
  logic [XLEN-1:0] ex_fwd_data, wb_fwd_data, src1, src2;
  logic stall_in, flush, alu_enable, out_valid, out_is_load;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .RADDR_W(RADDR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_rd_addr(in_rd_addr),
    .in_is_load(in_is_load), .in_op(in_op),
    .ex_fwd_we(ex_fwd_we), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
    .wb_fwd_we(wb_fwd_we), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .stall_in(stall_in), .flush(flush),
    .src1(src1), .src2(src2), .op(op), .alu_enable(alu_enable),
    .out_valid(out_valid), .out_rd_addr(out_rd_addr), .out_is_load(out_is_load)
  );

  // ---------------- vectors ----------------
  typedef struct {
    logic rst, stall, flush, valid;
    logic [4:0] rs1, rs2, rd;
    logic u1, u2, use_imm, ld;
    logic [31:0] d1, d2, imm;
    logic [3:0] op;
    logic ex_we, wb_we;
    logic [4:0] ex_rd, wb_rd;
    logic [31:0] ex_d, wb_d;
    logic e_ready, e_valid, eld, chk;
    logic [31:0] e1, e2;
    logic [3:0] eop;
    logic [4:0] erd;
  } vec_t;

  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t idle();
    vec_t v;
    v.rst = 0; v.stall = 0; v.flush = 0; v.valid = 0;
    v.rs1 = 0; v.rs2 = 0; v.rd = 0; v.u1 = 0; v.u2 = 0; v.use_imm = 0; v.ld = 0;
    v.d1 = 0; v.d2 = 0; v.imm = 0; v.op = `ALU_ADD;
    v.ex_we = 0; v.wb_we = 0; v.ex_rd = 0; v.wb_rd = 0; v.ex_d = 0; v.wb_d = 0;
    v.e_ready = 1; v.e_valid = 0; v.eld = 0; v.chk = 0;
    v.e1 = 0; v.e2 = 0; v.eop = `ALU_ADD; v.erd = 0;
    return v;
  endfunction

  // Accepted instruction with register-file operands.
  function automatic vec_t acc(input logic [4:0] a1, a2, input logic u1, u2,
                               input logic [31:0] d1, d2, imm, input logic ui,
                               input logic [4:0] rd, input logic ld, input logic [3:0] opc);
    vec_t v;
    v = idle();
    v.valid = 1; v.rs1 = a1; v.rs2 = a2; v.u1 = u1; v.u2 = u2;
    v.d1 = d1; v.d2 = d2; v.imm = imm; v.use_imm = ui; v.rd = rd; v.ld = ld; v.op = opc;
    v.e_valid = 1; v.e1 = d1; v.e2 = ui ? imm : d2; v.eop = opc; v.erd = rd; v.eld = ld;
    v.chk = 1;
    return v;
  endfunction

  function automatic vec_t bubble(input vec_t v);
    vec_t r;
    r = v; r.e_ready = 0; r.e_valid = 0; r.chk = 0;
    return r;
  endfunction

  function automatic vec_t cleared(input vec_t v);
    vec_t r;
    r = v; r.e_valid = 0; r.e1 = 0; r.e2 = 0; r.eop = `ALU_ADD; r.erd = 0; r.eld = 0; r.chk = 1;
    return r;
  endfunction

  function automatic vec_t held(input vec_t prev, input vec_t v);
    vec_t r;
    r = v; r.stall = 1; r.e_ready = 0;
    r.e_valid = prev.e_valid; r.e1 = prev.e1; r.e2 = prev.e2; r.eop = prev.eop;
    r.erd = prev.erd; r.eld = prev.eld; r.chk = prev.chk;
    return r;
  endfunction

  // ---------------- driver / scoreboard ----------------
  task automatic drive(input vec_t v);
    rst = v.rst; stall_in = v.stall; flush = v.flush; in_valid = v.valid;
    in_rs1_addr = v.rs1; in_rs2_addr = v.rs2; in_rs1_used = v.u1; in_rs2_used = v.u2;
    in_rs1_data = v.d1; in_rs2_data = v.d2; in_imm = v.imm; in_use_imm = v.use_imm;
    in_rd_addr = v.rd; in_is_load = v.ld; in_op = v.op;
    ex_fwd_we = v.ex_we; ex_fwd_rd = v.ex_rd; ex_fwd_data = v.ex_d;
    wb_fwd_we = v.wb_we; wb_fwd_rd = v.wb_rd; wb_fwd_data = v.wb_d;
  endtask

  task automatic cmp(input string name, input string what, input logic [31:0] got, want);
    if (got !== want) begin
      n_err++;
      $display("FAIL %s %s: got 0x%0h want 0x%0h", name, what, got, want);
    end
  endtask

  task automatic check_out(input string name);
    logic [EW-1:0] e;
    logic ev, eld, chk;
    logic [31:0] e1, e2;
    logic [3:0] eop;
    logic [4:0] erd;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s scoreboard: got empty queue want entry", name);
      return;
    end
    e = exp_q.pop_front();
    {ev, e1, e2, eop, erd, eld, chk} = e;
    cmp(name, "out_valid", {31'd0, out_valid}, {31'd0, ev});
    cmp(name, "alu_enable", {31'd0, alu_enable}, {31'd0, ev});
    if (chk) begin
      cmp(name, "src1", src1, e1);
      cmp(name, "src2", src2, e2);
      cmp(name, "op", {28'd0, op}, {28'd0, eop});
      cmp(name, "out_rd_addr", {27'd0, out_rd_addr}, {27'd0, erd});
      cmp(name, "out_is_load", {31'd0, out_is_load}, {31'd0, eld});
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    drive(v);
    #1;
    n_vec++;
    cmp(name, "in_ready", {31'd0, in_ready}, {31'd0, v.e_ready});
    exp_q.push_back({v.e_valid, v.e1, v.e2, v.eop, v.erd, v.eld, v.chk});
    @(posedge clk);
    #1;
    check_out(name);
  endtask

  // ---------------- test ----------------
  vec_t tbl[7];
  vec_t v, x, y, z, u;

  initial begin
    // Table: no bus activity and no dependence on the held rd, so it is
    // valid in both builds. State carries from row to row.
    tbl[0] = acc(5'd1, 5'd2, 1, 1, 32'd5, 32'd7, 32'd0, 0, 5'd5, 0, `ALU_ADD);
    tbl[1] = acc(5'd1, 5'd2, 1, 0, 32'hdeadbeef, 32'h1234, 32'hfffffff0, 1, 5'd7, 0, `ALU_SUB);
    tbl[2] = idle();
    tbl[3] = acc(5'd0, 5'd31, 1, 1, 32'h55, 32'ha5a5a5a5, 32'd0, 0, 5'd0, 0, `ALU_XOR);
    tbl[4] = acc(5'd0, 5'd0, 1, 1, 32'd1, 32'd2, 32'd0, 0, 5'd31, 1, `ALU_AND);
    tbl[5] = cleared(acc(5'd2, 5'd3, 0, 0, 32'h9, 32'h9, 32'd0, 0, 5'd4, 0, `ALU_OR));
    tbl[5].flush = 1;
    tbl[6] = acc(5'd31, 5'd3, 1, 1, 32'h80000000, 32'd1, 32'd0, 0, 5'd2, 0, `ALU_OR);

    // Reset: first edge brings the register to a known state.
    v = idle(); v.rst = 1;
    drive(v);
    @(posedge clk); #1;
    apply(cleared(v), "reset");

    for (int i = 0; i < 7; i++) begin
      apply(tbl[i], $sformatf("tbl%0d", i));
      if (i == 0) cmp("tbl0", "alu_sum", src1 + src2, 32'd12);
    end

    // Stall for 3 cycles with a new instruction waiting, then release.
    x = acc(5'd4, 5'd5, 1, 1, 32'h11, 32'h22, 32'd0, 0, 5'd9, 0, `ALU_SUB);
    y = acc(5'd1, 5'd6, 1, 1, 32'h33, 32'h44, 32'd0, 0, 5'd10, 0, `ALU_OR);
    apply(x, "stall_x");
    for (int i = 0; i < 3; i++) apply(held(x, y), $sformatf("stall_hold%0d", i));
    apply(y, "stall_release");
    apply(idle(), "stall_nodup");

    // Flush together with stall while valid.
    z = acc(5'd7, 5'd8, 1, 1, 32'habc, 32'hdef, 32'd0, 0, 5'd11, 0, `ALU_ADD);
    apply(z, "flush_z");
    v = cleared(y); v.stall = 1; v.flush = 1; v.e_ready = 0;
    apply(v, "flush_stall");
    apply(idle(), "flush_idle");

    // Reset in the middle of a stall.
    apply(z, "rststall_z");
    v = cleared(y); v.stall = 1; v.rst = 1; v.e_ready = 0;
    apply(v, "rst_stall");

    // x0 never forwarded or treated as a hazard.
    v = acc(5'd0, 5'd0, 1, 1, 32'h77, 32'h88, 32'd0, 0, 5'd12, 0, `ALU_ADD);
    v.ex_we = 1; v.ex_rd = 0; v.ex_d = 32'h999; v.wb_we = 1; v.wb_rd = 0; v.wb_d = 32'h666;
    apply(v, "x0_rf");

    // Immediate replaces rs2 even when rs2 matches the EX bus.
    v = acc(5'd1, 5'd20, 1, 0, 32'h10, 32'h20, 32'h5, 1, 5'd13, 0, `ALU_SUB);
    v.ex_we = 1; v.ex_rd = 20; v.ex_d = 32'h999;
    apply(v, "imm_src2");

    // Held load to x3, next instruction reads x3.
    apply(acc(5'd9, 5'd10, 1, 1, 32'd1, 32'd2, 32'd0, 0, 5'd3, 1, `ALU_ADD), "load_x3");
    u = acc(5'd3, 5'd13, 1, 1, 32'h1111, 32'h2222, 32'd0, 0, 5'd14, 0, `ALU_ADD);
`ifdef ID_EX_FORWARD_EN
    apply(bubble(u), "lu_bubble");
    v = u; v.ex_we = 1; v.ex_rd = 3; v.ex_d = 32'hcafe; v.e1 = 32'hcafe;
    apply(v, "lu_fwd");

    v = acc(5'd1, 5'd2, 1, 1, 32'd5, 32'd7, 32'd0, 0, 5'd16, 0, `ALU_ADD);
    v.ex_we = 1; v.ex_rd = 1; v.ex_d = 32'h100; v.wb_we = 1; v.wb_rd = 1; v.wb_d = 32'h200;
    v.e1 = 32'h100;
    apply(v, "ex_over_wb");

    v = acc(5'd1, 5'd2, 1, 1, 32'd5, 32'd7, 32'd0, 0, 5'd17, 0, `ALU_ADD);
    v.ex_we = 1; v.ex_rd = 6; v.ex_d = 32'h300; v.wb_we = 1; v.wb_rd = 2; v.wb_d = 32'h200;
    v.e2 = 32'h200;
    apply(v, "wb_fwd");

    v = acc(5'd1, 5'd2, 1, 1, 32'd5, 32'd7, 32'd0, 0, 5'd18, 0, `ALU_ADD);
    v.ex_rd = 1; v.ex_d = 32'hbad; v.wb_rd = 2; v.wb_d = 32'hbad;
    apply(v, "no_we");

    apply(acc(5'd18, 5'd3, 1, 1, 32'h55, 32'h66, 32'd0, 0, 5'd19, 0, `ALU_XOR), "alu_dep_nostall");
    apply(acc(5'd0, 5'd0, 1, 1, 32'd1, 32'd1, 32'd0, 0, 5'd0, 1, `ALU_ADD), "load_x0");
    apply(acc(5'd0, 5'd0, 1, 1, 32'd3, 32'd4, 32'd0, 0, 5'd20, 0, `ALU_ADD), "after_load_x0");
`else
    apply(bubble(u), "lu_pend");
    v = u; v.ex_we = 1; v.ex_rd = 3;
    apply(bubble(v), "lu_ex_hit");
    v = u; v.wb_we = 1; v.wb_rd = 3;
    apply(bubble(v), "lu_wb_hit");
    apply(u, "lu_accept");

    u = acc(5'd4, 5'd0, 1, 0, 32'h44, 32'd0, 32'd0, 0, 5'd15, 0, `ALU_ADD);
    v = u; v.wb_we = 1; v.wb_rd = 4; v.wb_d = 32'h999;
    apply(bubble(v), "wb_hit0");
    apply(bubble(v), "wb_hit1");
    apply(u, "wb_drop");

    u = acc(5'd15, 5'd0, 1, 0, 32'h15, 32'd0, 32'd0, 0, 5'd16, 0, `ALU_AND);
    apply(bubble(u), "pend_alu");
    apply(u, "pend_clear");
`endif

    apply(idle(), "final_idle");
    n_vec++;
    cmp("end", "queue_left", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
